dcache_evict_unit: RTL and testbench

//  Upstream feeder of the d$ write buffer. On a dirty-victim eviction it reads the victim line

---
 rtl/dcache_evict_unit_pkg.sv | 34 +++
 rtl/dcache_evict_unit_if.sv | 58 +++++
 rtl/dcache_evict_unit.sv | 106 ++++++++++
 tb/tb_dcache_evict_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_evict_unit_pkg.sv
// Shared definitions for the d$ eviction path and the write buffer it feeds.
// Holds physical address/word widths, the line label width helper, and the
// eviction FSM state encoding so both sides agree on one {label, data} line layout.
package dcache_evict_unit_pkg;

   localparam int PHYS_WIDTH      = 32;
   localparam int WORD_WIDTH      = 32;
   localparam int DEF_LINE_WIDTH  = 256;
   localparam int DEF_INDEX_WIDTH = 7;
   localparam int DEF_WAY_NUM     = 2;

   typedef logic [PHYS_WIDTH-1:0] phys_t;

   // Eviction FSM encoding, kept as plain constants for older consumers
   typedef logic [1:0] ev_state_t;
   localparam ev_state_t EV_IDLE  = 2'd0;
   localparam ev_state_t EV_READ  = 2'd1;
   localparam ev_state_t EV_DRAIN = 2'd2;
   localparam ev_state_t EV_PUSH  = 2'd3;

   // Select/counter width that never collapses to zero bits
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Number of byte-offset bits inside a line
   function automatic int line_byte_offset(input int line_width);
      return $clog2(line_width / 8);
   endfunction

   localparam int LINE_BYTE_OFFSET = line_byte_offset(DEF_LINE_WIDTH);
   localparam int DEF_LABEL_WIDTH  = PHYS_WIDTH - LINE_BYTE_OFFSET;

endpackage

// File: rtl/dcache_evict_unit_if.sv
// Bundle of every signal between the eviction unit and its neighbours:
// d$ eviction request, d$ data RAM read port, write-buffer push port, refill query.
// master = d$/RAM/write-buffer side, slave = the eviction unit.
interface dcache_evict_unit_if
   import dcache_evict_unit_pkg::*;
#(
   parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
   parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
   parameter int WAY_NUM     = DEF_WAY_NUM,
   parameter int LABEL_WIDTH = PHYS_WIDTH - line_byte_offset(LINE_WIDTH)
);
   localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
   localparam int CNT_W = cnt_width(WORDS);
   localparam int WAY_W = cnt_width(WAY_NUM);

   // eviction request from the d$
   logic                         evict_req;
   logic [LABEL_WIDTH-1:0]       evict_label;
   logic [INDEX_WIDTH-1:0]       evict_index;
   logic [WAY_W-1:0]             evict_way;
   logic                         evict_ready;
   logic                         evict_done;
   // d$ data RAM read port
   logic                         ram_en;
   logic [WAY_W-1:0]             ram_way;
   logic [INDEX_WIDTH+CNT_W-1:0] ram_addr;
   logic [WORD_WIDTH-1:0]        ram_rdata;
   // write-buffer push port
   logic [LABEL_WIDTH+LINE_WIDTH-1:0] pline;
   logic                         push;
   logic                         pushed;
   // refill address check
   logic [LABEL_WIDTH-1:0]       query_label;
   logic                         query_hit;

   modport master (
      output evict_req, evict_label, evict_index, evict_way,
      input  evict_ready, evict_done,
      input  ram_en, ram_way, ram_addr,
      output ram_rdata,
      input  pline, push,
      output pushed,
      output query_label,
      input  query_hit
   );

   modport slave (
      input  evict_req, evict_label, evict_index, evict_way,
      output evict_ready, evict_done,
      output ram_en, ram_way, ram_addr,
      input  ram_rdata,
      output pline, push,
      input  pushed,
      input  query_label,
      output query_hit
   );

endinterface

// File: rtl/dcache_evict_unit.sv
// Reads a dirty victim line word-by-word from the d$ data RAM and pushes {label, data} to the write buffer.
// Latency: req at T, RAM reads T+1..T+WORDS, push first asserted at T+WORDS+2.
// Backpressure: holds push/pline stable until pushed; no timeout, evict_ready low until the line is taken.
// Ports: clk, rst (sync, active-high), bus (slave): evict_req/label/index/way -> evict_ready/done,
//        ram_en/way/addr <- ram_rdata, pline/push <- pushed, query_label -> query_hit.
module dcache_evict_unit
   import dcache_evict_unit_pkg::*;
#(
   parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
   parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
   parameter int WAY_NUM     = DEF_WAY_NUM,
   parameter int LABEL_WIDTH = PHYS_WIDTH - line_byte_offset(LINE_WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   dcache_evict_unit_if.slave bus
);

   localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
   localparam int CNT_W = cnt_width(WORDS);
   localparam int WAY_W = cnt_width(WAY_NUM);
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

   ev_state_t              state;
   logic [CNT_W-1:0]       word_cnt;
   logic [LABEL_WIDTH-1:0] label_q;
   logic [INDEX_WIDTH-1:0] index_q;
   logic [WAY_W-1:0]       way_q;
   logic [WORD_WIDTH-1:0]  data_q [WORDS];
   logic [LINE_WIDTH-1:0]  line_data;
   logic                   rd_active;
   logic                   push_active;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EV_IDLE;
         word_cnt <= '0;
         label_q  <= '0;
         index_q  <= '0;
         way_q    <= '0;
         for (int i = 0; i < WORDS; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         case (state)
            EV_IDLE: begin
               if (bus.evict_req) begin
                  label_q  <= bus.evict_label;
                  index_q  <= bus.evict_index;
                  way_q    <= bus.evict_way;
                  word_cnt <= '0;
                  state    <= EV_READ;
               end
            end
            EV_READ: begin
               // RAM data lags the address by one cycle, so this cycle's
               // rdata belongs to the previous word
               if (word_cnt != '0) begin
                  data_q[word_cnt - 1'b1] <= bus.ram_rdata;
               end
               if (word_cnt == LAST_WORD) begin
                  word_cnt <= '0;
                  state    <= EV_DRAIN;
               end else begin
                  word_cnt <= word_cnt + 1'b1;
               end
            end
            EV_DRAIN: begin
               // last word arrives after the final read
               data_q[WORDS-1] <= bus.ram_rdata;
               state           <= EV_PUSH;
            end
            EV_PUSH: begin
               if (bus.pushed) begin
                  state <= EV_IDLE;
               end
            end
            default: begin
               state <= EV_IDLE;
            end
         endcase
      end
   end

   // word 0 (lowest address) lands in the line LSBs
   always_comb begin
      line_data = '0;
      for (int i = 0; i < WORDS; i++) begin
         line_data[WORD_WIDTH*i +: WORD_WIDTH] = data_q[i];
      end
   end

   assign rd_active   = (state == EV_READ);
   assign push_active = (state == EV_PUSH);

   assign bus.evict_ready = (state == EV_IDLE);
   assign bus.evict_done  = push_active && bus.pushed;
   assign bus.ram_en      = rd_active;
   assign bus.ram_way     = way_q;
   assign bus.ram_addr    = rd_active ? {index_q, word_cnt} : '0;
   assign bus.pline       = {label_q, line_data};
   assign bus.push        = push_active;
   // label_q is only meaningful while a line is in flight
   assign bus.query_hit   = (state != EV_IDLE) && (bus.query_label == label_q);

endmodule

// File: tb/tb_dcache_evict_unit.sv
// Directed bench for dcache_evict_unit: reset values, basic eviction timing and data,
// write-buffer backpressure with ignored requests, back-to-back evictions, mid-read reset.
module tb_dcache_evict_unit;
   import dcache_evict_unit_pkg::*;

   localparam int LW  = 256;
   localparam int IW  = 7;
   localparam int WN  = 2;
   localparam int LBW = 27;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dcache_evict_unit_if #(.LINE_WIDTH(LW), .INDEX_WIDTH(IW), .WAY_NUM(WN), .LABEL_WIDTH(LBW)) bus ();

   dcache_evict_unit #(.LINE_WIDTH(LW), .INDEX_WIDTH(IW), .WAY_NUM(WN), .LABEL_WIDTH(LBW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] ram_base;

   // data RAM model: word w of the current line reads as ram_base + w, one cycle after ram_en
   always @(posedge clk) begin
      if (bus.ram_en === 1'b1) begin
         bus.ram_rdata <= ram_base + 32'(bus.ram_addr[2:0]);
      end
   end

   function automatic logic [LBW+LW-1:0] make_line(input logic [LBW-1:0] lbl, input logic [31:0] base);
      logic [LBW+LW-1:0] l;
      l = '0;
      l[LBW+LW-1 -: LBW] = lbl;
      for (int i = 0; i < 8; i++) begin
         l[32*i +: 32] = base + 32'(i);
      end
      return l;
   endfunction

   // presents a request for one cycle; returns #1 after the edge that accepted it (cycle T+1)
   task automatic start_req(input logic [LBW-1:0] lbl, input logic [IW-1:0] idx, input logic way);
      bus.evict_req   = 1'b1;
      bus.evict_label = lbl;
      bus.evict_index = idx;
      bus.evict_way   = way;
      @(posedge clk); #1;
      bus.evict_req   = 1'b0;
      bus.evict_label = ~lbl;
      bus.evict_index = ~idx;
      bus.evict_way   = ~way;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.query_label = '0;
      @(posedge clk); @(posedge clk); #1;
      n_cmp++; if (bus.evict_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", bus.evict_ready); end
      n_cmp++; if (bus.evict_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.evict_done); end
      n_cmp++; if (bus.ram_en !== 1'b0) begin n_err++; $display("FAIL reset_ram_en got=%b exp=0", bus.ram_en); end
      n_cmp++; if (bus.push !== 1'b0) begin n_err++; $display("FAIL reset_push got=%b exp=0", bus.push); end
      n_cmp++; if (bus.query_hit !== 1'b0) begin n_err++; $display("FAIL reset_query_hit got=%b exp=0", bus.query_hit); end
      n_cmp++; if (bus.ram_addr !== 10'h0) begin n_err++; $display("FAIL reset_ram_addr got=%h exp=0", bus.ram_addr); end
      n_cmp++; if (bus.pline !== '0) begin n_err++; $display("FAIL reset_pline got=%h exp=0", bus.pline); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (bus.evict_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got=%b exp=1", bus.evict_ready); end
   endtask

   task automatic test_basic();
      logic [LBW+LW-1:0] exp_line;
      logic              exp_hit;
      exp_line = {27'h123456, 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0};
      ram_base = 32'hA0;
      bus.query_label = 27'h123456;
      start_req(27'h123456, 7'd5, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         if (k <= 8) begin
            n_cmp++;
            if (bus.ram_en !== 1'b1 || bus.ram_addr !== {7'd5, 3'(k-1)} || bus.ram_way !== 1'b1) begin
               n_err++;
               $display("FAIL basic_read T+%0d en=%b addr=%h way=%b exp en=1 addr=%h way=1",
                        k, bus.ram_en, bus.ram_addr, bus.ram_way, {7'd5, 3'(k-1)});
            end
         end else begin
            n_cmp++; if (bus.ram_en !== 1'b0) begin n_err++; $display("FAIL basic_drain_ram_en got=%b exp=0", bus.ram_en); end
         end
         n_cmp++;
         if (bus.push !== 1'b0 || bus.evict_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy T+%0d push=%b ready=%b exp push=0 ready=0", k, bus.push, bus.evict_ready);
         end
         bus.query_label = (k == 4) ? 27'h123457 : 27'h123456;
         exp_hit = (k != 4);
         #1;
         n_cmp++;
         if (bus.query_hit !== exp_hit) begin
            n_err++;
            $display("FAIL basic_query T+%0d got=%b exp=%b", k, bus.query_hit, exp_hit);
         end
         @(posedge clk); #1;
      end
      bus.query_label = 27'h123456;
      n_cmp++; if (bus.push !== 1'b1) begin n_err++; $display("FAIL basic_push_T10 got=%b exp=1", bus.push); end
      n_cmp++; if (bus.pline !== exp_line) begin n_err++; $display("FAIL basic_pline got=%h exp=%h", bus.pline, exp_line); end
      n_cmp++; if (bus.query_hit !== 1'b1) begin n_err++; $display("FAIL basic_query_push got=%b exp=1", bus.query_hit); end
      bus.pushed = 1'b1;
      #1;
      n_cmp++; if (bus.evict_done !== 1'b1) begin n_err++; $display("FAIL basic_done got=%b exp=1", bus.evict_done); end
      @(posedge clk); #1;
      bus.pushed = 1'b0;
      n_cmp++;
      if (bus.evict_done !== 1'b0 || bus.push !== 1'b0 || bus.evict_ready !== 1'b1) begin
         n_err++;
         $display("FAIL basic_after_done done=%b push=%b ready=%b exp done=0 push=0 ready=1",
                  bus.evict_done, bus.push, bus.evict_ready);
      end
      n_cmp++; if (bus.query_hit !== 1'b0) begin n_err++; $display("FAIL basic_query_idle got=%b exp=0", bus.query_hit); end
   endtask

   task automatic test_backpressure();
      logic [LBW+LW-1:0] exp_line;
      exp_line = make_line(27'h0ABCDEF, 32'h1000);
      ram_base = 32'h1000;
      bus.query_label = 27'h0ABCDEF;
      start_req(27'h0ABCDEF, 7'h12, 1'b0);
      for (int k = 1; k < 10; k++) begin
         @(posedge clk); #1;
      end
      n_cmp++; if (bus.push !== 1'b1) begin n_err++; $display("FAIL bp_push_T10 got=%b exp=1", bus.push); end
      // write buffer full for 20 cycles; stray requests must be ignored
      for (int c = 0; c < 20; c++) begin
         n_cmp++;
         if (bus.push !== 1'b1 || bus.pline !== exp_line || bus.evict_ready !== 1'b0 ||
             bus.evict_done !== 1'b0 || bus.ram_en !== 1'b0 || bus.query_hit !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold c=%0d push=%b ready=%b done=%b ram_en=%b hit=%b pline=%h exp push=1 ready=0 done=0 ram_en=0 hit=1 pline=%h",
                     c, bus.push, bus.evict_ready, bus.evict_done, bus.ram_en, bus.query_hit, bus.pline, exp_line);
         end
         bus.evict_req   = (c == 5) || (c == 12);
         bus.evict_label = 27'h7FFFFFF;
         bus.evict_index = 7'h00;
         bus.evict_way   = 1'b1;
         @(posedge clk); #1;
      end
      bus.evict_req = 1'b0;
      bus.pushed = 1'b1;
      #1;
      n_cmp++; if (bus.evict_done !== 1'b1) begin n_err++; $display("FAIL bp_done got=%b exp=1", bus.evict_done); end
      @(posedge clk); #1;
      bus.pushed = 1'b0;
      n_cmp++; if (bus.evict_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after got=%b exp=1", bus.evict_ready); end
   endtask

   task automatic test_back_to_back();
      logic [LBW+LW-1:0] exp_a;
      logic [LBW+LW-1:0] exp_b;
      exp_a = make_line(27'h0000111, 32'hA000_0000);
      exp_b = make_line(27'h0000222, 32'hB000_0000);
      ram_base = 32'hA000_0000;
      bus.query_label = 27'h0000222;
      start_req(27'h0000111, 7'd1, 1'b0);
      for (int k = 1; k < 10; k++) begin
         @(posedge clk); #1;
      end
      n_cmp++; if (bus.push !== 1'b1 || bus.pline !== exp_a) begin n_err++; $display("FAIL b2b_line_a push=%b pline=%h exp push=1 pline=%h", bus.push, bus.pline, exp_a); end
      bus.pushed = 1'b1;
      #1;
      n_cmp++; if (bus.evict_done !== 1'b1) begin n_err++; $display("FAIL b2b_done_a got=%b exp=1", bus.evict_done); end
      @(posedge clk); #1;
      bus.pushed = 1'b0;
      n_cmp++; if (bus.evict_ready !== 1'b1 || bus.evict_done !== 1'b0) begin n_err++; $display("FAIL b2b_idle ready=%b done=%b exp ready=1 done=0", bus.evict_ready, bus.evict_done); end
      ram_base = 32'hB000_0000;
      start_req(27'h0000222, 7'd2, 1'b1);
      n_cmp++;
      if (bus.ram_en !== 1'b1 || bus.ram_addr !== {7'd2, 3'd0} || bus.ram_way !== 1'b1 || bus.query_hit !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_read_b en=%b addr=%h way=%b hit=%b exp en=1 addr=%h way=1 hit=1",
                  bus.ram_en, bus.ram_addr, bus.ram_way, bus.query_hit, {7'd2, 3'd0});
      end
      for (int k = 1; k < 10; k++) begin
         @(posedge clk); #1;
      end
      n_cmp++; if (bus.push !== 1'b1 || bus.pline !== exp_b) begin n_err++; $display("FAIL b2b_line_b push=%b pline=%h exp push=1 pline=%h", bus.push, bus.pline, exp_b); end
      bus.pushed = 1'b1;
      #1;
      n_cmp++; if (bus.evict_done !== 1'b1) begin n_err++; $display("FAIL b2b_done_b got=%b exp=1", bus.evict_done); end
      @(posedge clk); #1;
      bus.pushed = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic saw_push;
      ram_base = 32'hC0;
      bus.query_label = 27'h1555555;
      start_req(27'h1555555, 7'd3, 1'b0);
      for (int k = 1; k < 4; k++) begin
         @(posedge clk); #1;
      end
      n_cmp++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== {7'd3, 3'd3}) begin n_err++; $display("FAIL mid_read_T4 en=%b addr=%h exp en=1 addr=%h", bus.ram_en, bus.ram_addr, {7'd3, 3'd3}); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++;
      if (bus.evict_ready !== 1'b1 || bus.ram_en !== 1'b0 || bus.push !== 1'b0 ||
          bus.query_hit !== 1'b0 || bus.ram_addr !== 10'h0) begin
         n_err++;
         $display("FAIL mid_reset ready=%b ram_en=%b push=%b hit=%b addr=%h exp ready=1 ram_en=0 push=0 hit=0 addr=0",
                  bus.evict_ready, bus.ram_en, bus.push, bus.query_hit, bus.ram_addr);
      end
      saw_push = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (bus.push !== 1'b0) saw_push = 1'b1;
         @(posedge clk); #1;
      end
      n_cmp++; if (saw_push !== 1'b0) begin n_err++; $display("FAIL mid_no_push saw_push=%b exp=0", saw_push); end
      n_cmp++; if (bus.evict_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_final got=%b exp=1", bus.evict_ready); end
   endtask

   initial begin
      rst             = 1'b1;
      bus.evict_req   = 1'b0;
      bus.evict_label = '0;
      bus.evict_index = '0;
      bus.evict_way   = 1'b0;
      bus.pushed      = 1'b0;
      bus.query_label = '0;
      ram_base        = 32'h0;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
